// File: rtl/bsg_fpu_cmp_pkg.sv
// bsg_fpu_cmp_pkg: shared op encoding, operand classification and canonical qNaN helper
package bsg_fpu_cmp_pkg;
  typedef enum logic [2:0] {
    e_cmp_eq  = 3'd0,
    e_cmp_lt  = 3'd1,
    e_cmp_le  = 3'd2,
    e_cmp_min = 3'd3,
    e_cmp_max = 3'd4
  } bsg_fpu_cmp_op_e;
  typedef struct packed {
    logic zero;
    logic nan;
    logic snan;
    logic sign;
  } cls_s;
  // Positive quiet NaN: exponent all ones, only the mantissa msb set
  function automatic logic [63:0] canon_qnan(input int e, input int m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < e; i++) r[m+i] = 1'b1;
    r[m-1] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/bsg_fpu_cmp_pipe_if.sv
// bsg_fpu_cmp_pipe_if: operand/result handshake bundle of the compare pipe
interface bsg_fpu_cmp_pipe_if #(parameter int e_p = 8, parameter int m_p = 23);
  localparam int width_lp = e_p + m_p + 1;
  logic                v_i;
  logic                ready_o;
  logic [width_lp-1:0] a_i;
  logic [width_lp-1:0] b_i;
  logic [2:0]          op_i;
  logic                v_o;
  logic                yumi_i;
  logic [width_lp-1:0] data_o;
  logic                flag_o;
  logic                invalid_o;
  logic                invalid_sticky_o;
  logic                clear_sticky_i;
  modport master (output v_i, a_i, b_i, op_i, yumi_i, clear_sticky_i,
                  input ready_o, v_o, data_o, flag_o, invalid_o, invalid_sticky_o);
  modport slave  (input v_i, a_i, b_i, op_i, yumi_i, clear_sticky_i,
                  output ready_o, v_o, data_o, flag_o, invalid_o, invalid_sticky_o);
endinterface

// File: rtl/bsg_fpu_cmp_pipe_classify.sv
// bsg_fpu_classify: combinational zero/NaN/sNaN/sign decode of one operand
module bsg_fpu_classify
  import bsg_fpu_cmp_pkg::*;
#(parameter int e_p = 8, parameter int m_p = 23)
(
  input  logic [e_p+m_p:0] x_i,
  output cls_s             cls_o
);
  always_comb begin
    cls_o.sign = x_i[e_p+m_p];
    cls_o.nan  = (&x_i[e_p+m_p-1:m_p]) & (|x_i[m_p-1:0]);
    cls_o.snan = cls_o.nan & !x_i[m_p-1];
    cls_o.zero = ~|x_i[e_p+m_p-1:0];
  end
endmodule

// File: rtl/bsg_fpu_cmp_pipe.sv
// bsg_fpu_cmp_pipe: 2-stage IEEE-754 EQ/LT/LE/MIN/MAX unit with sticky invalid flag
module bsg_fpu_cmp_pipe
  import bsg_fpu_cmp_pkg::*;
#(parameter int e_p = 8, parameter int m_p = 23)
(
  input logic               clk_i,
  input logic               reset_i,
  bsg_fpu_cmp_pipe_if.slave io
);
  localparam int width_lp = e_p + m_p + 1;
  localparam logic [width_lp-1:0] qnan_lp = width_lp'(canon_qnan(e_p, m_p));
  typedef struct packed {
    logic [width_lp-1:0] a;
    logic [width_lp-1:0] b;
    bsg_fpu_cmp_op_e     op;
    cls_s                a_cls;
    cls_s                b_cls;
  } s1_s;
  cls_s a_cls, b_cls;
  s1_s s1_d, s1_q;
  logic s1_v_d, s1_v_q, s2_v_d, s2_v_q, s1_adv, s2_adv;
  logic [width_lp-1:0] data_d, data_q;
  logic flag_d, flag_q, inv_d, inv_q, sticky_d, sticky_q;
  logic mag_lt, bit_eq, lt_raw, le_raw, any_nan, both_nan, both_zero, any_snan, is_mm;
  logic [width_lp-1:0] zero_v, sel_v, mm_v, res_data;
  logic res_flag, res_inv;
  bsg_fpu_classify #(.e_p(e_p), .m_p(m_p)) cls_a (.x_i(io.a_i), .cls_o(a_cls));
  bsg_fpu_classify #(.e_p(e_p), .m_p(m_p)) cls_b (.x_i(io.b_i), .cls_o(b_cls));
  always_comb begin
    mag_lt    = s1_q.a[width_lp-2:0] < s1_q.b[width_lp-2:0];
    bit_eq    = s1_q.a == s1_q.b;
    lt_raw    = s1_q.a_cls.sign ? (s1_q.b_cls.sign ? (!mag_lt & !bit_eq) : 1'b1)
                                : (s1_q.b_cls.sign ? 1'b0 : mag_lt);
    le_raw    = lt_raw | bit_eq;
    any_nan   = s1_q.a_cls.nan | s1_q.b_cls.nan;
    both_nan  = s1_q.a_cls.nan & s1_q.b_cls.nan;
    both_zero = s1_q.a_cls.zero & s1_q.b_cls.zero;
    any_snan  = s1_q.a_cls.snan | s1_q.b_cls.snan;
    is_mm     = (s1_q.op == e_cmp_min) | (s1_q.op == e_cmp_max);
    zero_v    = '0;
    zero_v[width_lp-1] = (s1_q.op == e_cmp_max) ? (s1_q.a_cls.sign & s1_q.b_cls.sign)
                                                : (s1_q.a_cls.sign | s1_q.b_cls.sign);
    // MIN picks a when a<b, MAX picks a when !(a<b)
    sel_v     = (lt_raw ^ (s1_q.op == e_cmp_max)) ? s1_q.a : s1_q.b;
    mm_v      = both_nan ? qnan_lp : s1_q.a_cls.nan ? s1_q.b : s1_q.b_cls.nan ? s1_q.a
              : both_zero ? zero_v : sel_v;
    res_flag  = (s1_q.op == e_cmp_eq) ? (!any_nan & (both_zero | bit_eq))
              : (s1_q.op == e_cmp_lt) ? (!any_nan & !both_zero & lt_raw)
              : (s1_q.op == e_cmp_le) ? (!any_nan & (both_zero | le_raw)) : 1'b0;
    res_inv   = ((s1_q.op == e_cmp_eq) | is_mm) ? any_snan
              : ((s1_q.op == e_cmp_lt) | (s1_q.op == e_cmp_le)) ? any_nan : 1'b0;
    res_data  = is_mm ? mm_v : {{(width_lp-1){1'b0}}, res_flag};
  end
  always_comb begin
    s2_adv   = !s2_v_q | io.yumi_i;
    s1_adv   = !s1_v_q | s2_adv;
    s1_v_d   = s1_adv ? io.v_i : s1_v_q;
    s1_d     = s1_adv ? s1_s'{a: io.a_i, b: io.b_i, op: bsg_fpu_cmp_op_e'(io.op_i),
                              a_cls: a_cls, b_cls: b_cls} : s1_q;
    s2_v_d   = s2_adv ? s1_v_q : s2_v_q;
    data_d   = s2_adv ? res_data : data_q;
    flag_d   = s2_adv ? res_flag : flag_q;
    inv_d    = s2_adv ? res_inv : inv_q;
    sticky_d = (s2_v_q & io.yumi_i & inv_q) | (sticky_q & !io.clear_sticky_i);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_v_q   <= 1'b0;
      s1_q     <= '0;
      s2_v_q   <= 1'b0;
      data_q   <= '0;
      flag_q   <= 1'b0;
      inv_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_q     <= s1_d;
      s2_v_q   <= s2_v_d;
      data_q   <= data_d;
      flag_q   <= flag_d;
      inv_q    <= inv_d;
      sticky_q <= sticky_d;
    end
  end
  assign io.ready_o          = s1_adv;
  assign io.v_o              = s2_v_q;
  assign io.data_o           = data_q;
  assign io.flag_o           = flag_q;
  assign io.invalid_o        = inv_q;
  assign io.invalid_sticky_o = sticky_q;
endmodule

// File: tb/tb_bsg_fpu_cmp_pipe.sv
// tb_bsg_fpu_cmp_pipe: vector table plus scoreboard checks of the compare pipe
module tb_bsg_fpu_cmp_pipe;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  bsg_fpu_cmp_pipe_if #(.e_p(8), .m_p(23)) io ();
  bsg_fpu_cmp_pipe #(.e_p(8), .m_p(23)) dut (.clk_i(clk), .reset_i(rst), .io(io));
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        flag;
    logic        inv;
  } vec_t;
  vec_t sbq[$];
  vec_t tbl[$];
  vec_t bp[5];
  int total = 0, passed = 0;
  int n_res = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask
  task automatic timeout(input string name);
    total++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask
  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] d, input logic f, input logic i);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.data = d; v.flag = f; v.inv = i;
    return v;
  endfunction
  always @(negedge clk) begin
    if (!rst && io.v_o && io.yumi_i) begin
      n_res++;
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL extra_result actual=%h required=none", io.data_o);
      end else begin
        vec_t e;
        e = sbq.pop_front();
        chk($sformatf("res%0d_data", n_res), io.data_o, e.data);
        chk($sformatf("res%0d_flag", n_res), {31'b0, io.flag_o}, {31'b0, e.flag});
        chk($sformatf("res%0d_inv", n_res), {31'b0, io.invalid_o}, {31'b0, e.inv});
      end
    end
  end
  task automatic send(input vec_t v, input bit push);
    int n;
    n = 0;
    io.v_i = 1; io.op_i = v.op; io.a_i = v.a; io.b_i = v.b;
    @(negedge clk);
    while (!io.ready_o && n < 50) begin n++; @(negedge clk); end
    if (!io.ready_o) timeout("accept");
    else if (push) sbq.push_back(v);
    @(posedge clk); #1;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin n++; @(negedge clk); end
    if (sbq.size() != 0) timeout("drain");
    @(posedge clk); #1;
  endtask
  task automatic wait_vo();
    int n;
    n = 0;
    @(negedge clk);
    while (!io.v_o && n < 20) begin n++; @(negedge clk); end
    if (!io.v_o) timeout("wait_v_o");
  endtask
  initial begin
    logic [31:0] d0;
    int run, stale;
    io.v_i = 0; io.a_i = 0; io.b_i = 0; io.op_i = 0; io.yumi_i = 0; io.clear_sticky_i = 0;
    tbl.push_back(mk(3'd1, 32'h3F800000, 32'h40000000, 32'h1, 1, 0));
    tbl.push_back(mk(3'd2, 32'hC0000000, 32'hC0000000, 32'h1, 1, 0));
    tbl.push_back(mk(3'd1, 32'hC0000000, 32'hBF800000, 32'h1, 1, 0));
    tbl.push_back(mk(3'd1, 32'h40000000, 32'h3F800000, 32'h0, 0, 0));
    tbl.push_back(mk(3'd0, 32'h00000000, 32'h80000000, 32'h1, 1, 0));
    tbl.push_back(mk(3'd3, 32'h00000000, 32'h80000000, 32'h80000000, 0, 0));
    tbl.push_back(mk(3'd4, 32'h00000000, 32'h80000000, 32'h00000000, 0, 0));
    tbl.push_back(mk(3'd0, 32'h7FC00000, 32'h3F800000, 32'h0, 0, 0));
    tbl.push_back(mk(3'd0, 32'h7FA00000, 32'h3F800000, 32'h0, 0, 1));
    tbl.push_back(mk(3'd1, 32'h7FC00000, 32'h3F800000, 32'h0, 0, 1));
    tbl.push_back(mk(3'd3, 32'h7FA00000, 32'h40000000, 32'h40000000, 0, 1));
    tbl.push_back(mk(3'd4, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 0, 0));
    tbl.push_back(mk(3'd1, 32'h00000000, 32'h80000000, 32'h0, 0, 0));
    tbl.push_back(mk(3'd2, 32'h00000000, 32'h80000000, 32'h1, 1, 0));
    tbl.push_back(mk(3'd3, 32'h3F800000, 32'hBF800000, 32'hBF800000, 0, 0));
    tbl.push_back(mk(3'd4, 32'h3F800000, 32'hBF800000, 32'h3F800000, 0, 0));
    tbl.push_back(mk(3'd0, 32'h3F800000, 32'h3F800000, 32'h1, 1, 0));
    tbl.push_back(mk(3'd6, 32'h3F800000, 32'h3F800000, 32'h0, 0, 0));
    tbl.push_back(mk(3'd7, 32'h7FA00000, 32'h00000000, 32'h0, 0, 0));
    tbl.push_back(mk(3'd4, 32'h3F800000, 32'h7FC00000, 32'h3F800000, 0, 0));
    tbl.push_back(mk(3'd3, 32'h7F800000, 32'h7FA00000, 32'h7F800000, 0, 1));
    tbl.push_back(mk(3'd2, 32'hBF800000, 32'hC0000000, 32'h0, 0, 0));
    tbl.push_back(mk(3'd4, 32'h7FA00000, 32'h7FC00000, 32'h7FC00000, 0, 1));
    tbl.push_back(mk(3'd1, 32'h00000001, 32'h00000002, 32'h1, 1, 0));
    bp[0] = mk(3'd4, 32'h3F800000, 32'h40000000, 32'h40000000, 0, 0);
    bp[1] = mk(3'd3, 32'h3F800000, 32'h40000000, 32'h3F800000, 0, 0);
    bp[2] = mk(3'd1, 32'h3F800000, 32'h40000000, 32'h1, 1, 0);
    bp[3] = mk(3'd0, 32'h40000000, 32'h40000000, 32'h1, 1, 0);
    bp[4] = mk(3'd4, 32'hBF800000, 32'hC0000000, 32'hBF800000, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_v_o", {31'b0, io.v_o}, 0);
    chk("reset_data_o", io.data_o, 0);
    chk("reset_flag_o", {31'b0, io.flag_o}, 0);
    chk("reset_invalid_o", {31'b0, io.invalid_o}, 0);
    chk("reset_sticky", {31'b0, io.invalid_sticky_o}, 0);
    chk("reset_ready_o", {31'b0, io.ready_o}, 1);
    @(posedge clk); #1;
    io.yumi_i = 1;
    send(tbl[0], 1);
    io.v_i = 0;
    @(negedge clk);
    chk("latency_cycle1_v_o", {31'b0, io.v_o}, 0);
    @(negedge clk);
    chk("latency_cycle2_v_o", {31'b0, io.v_o}, 1);
    @(posedge clk); #1;
    foreach (tbl[i]) send(tbl[i], 1);
    io.v_i = 0;
    drain();
    io.yumi_i = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(bp[i], 1);
        io.v_i = 0;
      end
      begin
        repeat (3) @(negedge clk);
        d0 = io.data_o;
        chk("stall_head_data", d0, 32'h40000000);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_data_stable", io.data_o, d0);
          chk("stall_v_o", {31'b0, io.v_o}, 1);
        end
        chk("stall_ready_o", {31'b0, io.ready_o}, 0);
        chk("stall_accepted", sbq.size(), 2);
        @(posedge clk); #1 io.yumi_i = 1;
        run = 0;
        @(negedge clk);
        while (io.v_o && run < 20) begin run++; @(negedge clk); end
        chk("bp_burst_len", run, 5);
      end
    join
    drain();
    chk("bp_queue_empty", sbq.size(), 0);
    io.yumi_i = 0;
    io.clear_sticky_i = 1;
    @(posedge clk); #1 io.clear_sticky_i = 0;
    @(negedge clk);
    chk("sticky_cleared", {31'b0, io.invalid_sticky_o}, 0);
    @(posedge clk); #1;
    send(mk(3'd1, 32'h7FC00000, 32'h3F800000, 32'h0, 0, 1), 1);
    io.v_i = 0;
    wait_vo();
    repeat (3) @(negedge clk);
    chk("sticky_unconsumed", {31'b0, io.invalid_sticky_o}, 0);
    @(posedge clk); #1 io.yumi_i = 1;
    @(posedge clk); #1 io.yumi_i = 0;
    @(negedge clk);
    chk("sticky_set", {31'b0, io.invalid_sticky_o}, 1);
    @(posedge clk); #1;
    send(mk(3'd0, 32'h7FA00000, 32'h3F800000, 32'h0, 0, 1), 1);
    io.v_i = 0;
    wait_vo();
    @(posedge clk); #1 io.yumi_i = 1; io.clear_sticky_i = 1;
    @(posedge clk); #1 io.yumi_i = 0; io.clear_sticky_i = 0;
    @(negedge clk);
    chk("sticky_set_wins", {31'b0, io.invalid_sticky_o}, 1);
    @(posedge clk); #1 io.clear_sticky_i = 1;
    @(posedge clk); #1 io.clear_sticky_i = 0;
    @(negedge clk);
    chk("sticky_clear_alone", {31'b0, io.invalid_sticky_o}, 0);
    @(posedge clk); #1 io.yumi_i = 1;
    send(mk(3'd2, 32'h7FC00000, 32'h7FC00000, 32'h0, 0, 1), 1);
    io.v_i = 0;
    drain();
    chk("sticky_before_reset", {31'b0, io.invalid_sticky_o}, 1);
    io.yumi_i = 0;
    send(bp[0], 0);
    send(bp[1], 0);
    io.v_i = 0;
    @(negedge clk);
    chk("inflight_ready_o", {31'b0, io.ready_o}, 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midreset_v_o", {31'b0, io.v_o}, 0);
    chk("midreset_sticky", {31'b0, io.invalid_sticky_o}, 0);
    chk("midreset_ready_o", {31'b0, io.ready_o}, 1);
    chk("midreset_data_o", io.data_o, 0);
    @(posedge clk); #1 io.yumi_i = 1;
    stale = 0;
    repeat (5) begin @(negedge clk); if (io.v_o) stale++; end
    chk("no_stale_results", stale, 0);
    @(posedge clk); #1;
    send(mk(3'd6, 32'h3F800000, 32'h40000000, 32'h0, 0, 0), 1);
    io.v_i = 0;
    drain();
    chk("final_queue_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
